// File: rtl/arb_wrr_pkg.sv
// rtl/arb_wrr_pkg.sv - shared state encoding and credit sizing for the weighted round-robin arbiter
package arb_wrr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A burst never exceeds the largest programmable weight, so credit needs the weight width.
  function automatic int credit_width(input int weight_w);
    return (weight_w < 1) ? 1 : weight_w;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational rotate-priority-rotate picker, search starts one past ptr_i
module arb_rr_pick
  import arb_wrr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] shifted;
  logic [IW-1:0]  k_sel;
  logic [IW:0]    sum;

  always_comb begin
    start   = (ptr_i == IW'(N - 1)) ? '0 : ptr_i + IW'(1);
    shifted = {req_i, req_i} >> start;
    any_o   = 1'b0;
    k_sel   = '0;
    // Descending scan so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (shifted[k]) begin
        any_o = 1'b1;
        k_sel = IW'(k);
      end
    end
    sum   = {1'b0, start} + {1'b0, k_sel};
    idx_o = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/arb_wrr.sv
// rtl/arb_wrr.sv - weighted round-robin arbiter top; macro ARB_WRR_WEIGHT_EN enables weighted bursts
module arb_wrr
  import arb_wrr_pkg::*;
#(
  parameter int WIDTH_REQ = 8,
  parameter int WEIGHT_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH_REQ-1:0]          req,
  output logic [WIDTH_REQ-1:0]          req_rdy,
  output logic [WIDTH_REQ-1:0]          gnt,
  output logic [$clog2(WIDTH_REQ)-1:0]  gnt_idx,
  input  logic                          gnt_rdy,
  input  logic [WIDTH_REQ*WEIGHT_W-1:0] weight
);

  localparam int IW = $clog2(WIDTH_REQ);
  localparam int CW = credit_width(WEIGHT_W);

  state_t               state_q, state_d;
  logic [WIDTH_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic [IW-1:0]        ptr_q, ptr_d;

  logic [IW-1:0]        pick_ptr;
  logic [WIDTH_REQ-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [CW-1:0]        credit_load;
  logic                 issue;

  // While granting, the only re-arbitration is the one that moves ptr to idx, so search from idx.
  assign pick_ptr = (state_q == GRANT) ? idx_q : ptr_q;

  arb_rr_pick #(.N(WIDTH_REQ)) u_pick (
    .req_i (req),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef ARB_WRR_WEIGHT_EN
  logic [WEIGHT_W-1:0] weight_sel;
  assign weight_sel  = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign credit_load = (weight_sel == '0) ? CW'(1) : CW'(weight_sel);
`else
  logic weight_unused;
  assign weight_unused = ^weight;
  assign credit_load   = CW'(1);
`endif

  assign req_rdy = gnt_q & req & {WIDTH_REQ{gnt_rdy & ~reset}};
  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: issue = pick_any;
      GRANT: begin
        if (gnt_rdy) begin
          if (req[idx_q] && (credit_q > CW'(1))) begin
            credit_d = credit_q - CW'(1);
          end else begin
            // Last credit spent or requester abandoned: leftover credit is dropped.
            ptr_d    = idx_q;
            issue    = pick_any;
            state_d  = IDLE;
            gnt_d    = '0;
            idx_d    = '0;
            credit_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d  = GRANT;
      gnt_d    = pick_gnt;
      idx_d    = pick_idx;
      credit_d = credit_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      credit_q <= '0;
      ptr_q    <= IW'(WIDTH_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule
